// File: rtl/wide_add_sub_seq_pkg.sv
// Shared types for the multi-word add/subtract sequencer.
// Holds the FSM state encoding and the opcode constants.
package wide_add_sub_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_sub.sv
// Single-word adder/subtractor with carry in and carry out.
// cnt=1 inverts b so that a - b is formed with cin=1.
module adder_sub #(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    input  logic         cnt,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n-1:0] b_eff;

    always_comb begin
        b_eff       = cnt ? ~b : b;
        {cout, s}   = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, cin};
    end

endmodule

// File: rtl/wide_add_sub_seq.sv
// Streams WORDS n-bit words, LSW first, through one adder_sub to form a
// WORDS*n-bit add or subtract, with valid/ready on both operand and result.
module wide_add_sub_seq
    import wide_add_sub_seq_pkg::*;
#(
    parameter int unsigned n     = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sub,
    input  logic [WORDS*n-1:0] op_a,
    input  logic [WORDS*n-1:0] op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDS*n-1:0] res,
    output logic               carry,
    output logic               zero,
    output logic               ovf
);

    localparam int unsigned W  = WORDS * n;
    localparam int unsigned IW = $clog2(WORDS);
    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  op_a_q, op_a_d;
    logic [W-1:0]  op_b_q, op_b_d;
    logic          sub_q, sub_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  res_q, res_d;
    logic          cf_q, cf_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;

    logic [n-1:0]  word_a, word_b, word_s;
    logic          word_cout;
    logic [W-1:0]  word_res;
    logic          a_m, b_m, r_m;

    assign word_a = op_a_q[idx_q*n +: n];
    assign word_b = op_b_q[idx_q*n +: n];

    adder_sub #(
        .n (n)
    ) u_adder_sub (
        .a    (word_a),
        .b    (word_b),
        .cin  (carry_q),
        .cnt  (sub_q),
        .s    (word_s),
        .cout (word_cout)
    );

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        res_d       = res_q;
        cf_d        = cf_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        // Result with the current word merged in; on the last word this is final.
        word_res                  = res_q;
        word_res[idx_q*n +: n]    = word_s;
        a_m                       = op_a_q[W-1];
        b_m                       = op_b_q[W-1];
        r_m                       = word_res[W-1];

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;  // +1 of the two's-complement negation
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d   = word_res;
                carry_d = word_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cf_d        = word_cout;
                    zero_d      = (word_res == '0);
                    ovf_d       = (sub_q == OP_SUB) ? ((a_m != b_m) && (r_m != a_m))
                                                    : ((a_m == b_m) && (r_m != a_m));
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sub_q       <= OP_ADD;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            cf_q        <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            cf_q        <= cf_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign carry     = cf_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sub_seq.sv
// Directed bench for wide_add_sub_seq (n=32, WORDS=4) with an arithmetic
// reference model and a per-cycle output checker.
module tb_wide_add_sub_seq;

    localparam int unsigned N  = 32;
    localparam int unsigned WD = 4;
    localparam int unsigned W  = N * WD;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         ovf;

    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_cur  = '0;

    wide_add_sub_seq #(
        .n     (N),
        .WORDS (WD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: wide arithmetic, overflow from the exact signed result.
    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t              e;
        logic [W:0]        full;
        logic signed [W+1:0] sa, sb, exact, wrapped;
        full    = s ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b});
        sa      = $signed({{2{a[W-1]}}, a});
        sb      = $signed({{2{b[W-1]}}, b});
        exact   = s ? (sa - sb) : (sa + sb);
        wrapped = $signed({{2{full[W-1]}}, full[W-1:0]});
        e.r     = full[W-1:0];
        e.c     = full[W];
        e.z     = (full[W-1:0] == '0);
        e.o     = (exact != wrapped);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Output checker: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            chk("res_model", res, exp_cur.r);
            chk("carry_model", W'(carry), W'(exp_cur.c));
            chk("zero_model", W'(zero), W'(exp_cur.z));
            chk("ovf_model", W'(ovf), W'(exp_cur.o));
            chk("in_ready_done", W'(in_ready), W'(0));
        end
    end

    task automatic accept(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        chk("in_ready_idle", W'(in_ready), W'(1));
        in_valid = 1'b1;
        sub      = s;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        exp_cur  = model(s, a, b);
        #1;
        in_valid = 1'b0;
        op_a     = '1;
        op_b     = '1;
        sub      = ~s;
    endtask

    task automatic run_op(input string nm, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t lit, input int hold);
        int lat;
        accept(s, a, b);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, W'(lat), W'(WD));
        chk({nm, "_res"}, res, lit.r);
        chk({nm, "_flags"}, W'({carry, zero, ovf}), W'({lit.c, lit.z, lit.o}));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({nm, "_held_valid"}, W'(out_valid), W'(1));
            chk({nm, "_held_res"}, res, lit.r);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_drain"}, W'(out_valid), W'(0));
    endtask

    initial begin
        exp_t lit;

        // Reset held with in_valid asserted: nothing may be accepted.
        rst      = 1'b0;
        in_valid = 1'b1;
        op_a     = 128'h5;
        op_b     = 128'h7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_res", res, '0);
        chk("rst_flags", W'({carry, zero, ovf}), W'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_no_accept", W'(out_valid), W'(0));

        lit = '{r: 128'h0000_0001_0000_0000_0000_0000_0000_0000, c: 1'b0, z: 1'b0, o: 1'b0};
        run_op("carry_chain", 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, lit, 0);

        lit = '{r: {W{1'b1}}, c: 1'b0, z: 1'b0, o: 1'b0};
        run_op("borrow", 1'b1, 128'h0, 128'h1, lit, 0);

        lit = '{r: 128'h0, c: 1'b1, z: 1'b1, o: 1'b0};
        run_op("equal_sub", 1'b1, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
               128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, lit, 0);

        lit = '{r: 128'h8000_0000_0000_0000_0000_0000_0000_0000, c: 1'b0, z: 1'b0, o: 1'b1};
        run_op("add_ovf", 1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, lit, 0);

        lit = '{r: 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, c: 1'b1, z: 1'b0, o: 1'b1};
        run_op("sub_ovf", 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1, lit, 0);

        // Backpressure: most-negative + most-negative wraps to zero.
        lit = '{r: 128'h0, c: 1'b1, z: 1'b1, o: 1'b1};
        run_op("backpressure", 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, lit, 10);

        // Abort mid-run: reset discards the operation.
        accept(1'b0, 128'h3, 128'h4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_idle", W'(in_ready), W'(1));
        @(negedge clk);
        rst = 1'b1;
        repeat (WD + 2) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", W'(out_valid), W'(0));
        end

        lit = '{r: 128'd12, c: 1'b0, z: 1'b0, o: 1'b0};
        run_op("after_abort", 1'b0, 128'd5, 128'd7, lit, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
